// File: rtl/uart_tx_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_feeder
//  Purpose  : Buffered byte writer for a UART transmitter. Bytes arrive on a
//             valid/ready stream, are queued in a circular FIFO and are
//             handed to the transmitter's din/wr_en/tx_busy interface one
//             byte per frame. A lost write (tx_busy never rises) is flagged
//             by a sticky timeout error.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_feeder #(
    parameter int DEPTH        = 16,
    parameter int ADDR_W       = 4,
    parameter int BUSY_TIMEOUT = 1024
) (
    input  logic              system_clk,
    input  logic              reset,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [7:0]        uart_din,
    output logic              uart_wr_en,
    input  logic              uart_tx_busy,
    output logic [ADDR_W:0]   fifo_count,
    output logic              fifo_empty,
    output logic              idle,
    output logic              timeout_err
);

    // The timer only ever has to hold values up to BUSY_TIMEOUT-1.
    localparam int TMR_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

    localparam logic [ADDR_W:0]   C_DEPTH    = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   C_CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] C_PTR_ONE  = ADDR_W'(1);
    localparam logic [TMR_W-1:0]  C_TMR_ONE  = TMR_W'(1);
    localparam logic [TMR_W-1:0]  C_TMO_LAST = TMR_W'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_BUSY = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [7:0]          r_mem [DEPTH];
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W-1:0]   r_rd_ptr;
    logic [ADDR_W:0]     r_count;
    logic [7:0]          r_din;
    logic                r_wr_en;
    logic                r_err;
    logic [TMR_W-1:0]    r_timer;

    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic                w_timer_inc;
    logic                w_set_err;

    // Ready depends only on the stored count, so a full FIFO refuses data
    // even in a cycle where the FSM pops (no pass-through path).
    assign w_full  = (r_count == C_DEPTH);
    assign w_empty = (r_count == '0);
    assign w_push  = s_valid && !w_full;

    // Byte storage: written at the tail pointer on every accepted transfer.
    always_ff @(posedge system_clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= s_data;
        end
    end

    // Pointers wrap naturally at DEPTH; the count is tracked separately so
    // full and empty are unambiguous.
    always_ff @(posedge system_clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + C_CNT_ONE;
                2'b01:   r_count <= r_count - C_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // State register of the drain sequencer.
    always_ff @(posedge system_clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and control decode: pop only when idle with data queued
    // and the transmitter free; the byte is dropped if busy never rises.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_timer_inc = 1'b0;
        w_set_err   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty && !uart_tx_busy) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_BUSY: begin
                if (uart_tx_busy) begin
                    w_state_nxt = ST_WAIT_DONE;
                end else if (r_timer == C_TMO_LAST) begin
                    w_set_err   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_timer_inc = 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (!uart_tx_busy) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Registered transmitter interface, busy-wait timer and sticky error.
    always_ff @(posedge system_clk or negedge reset) begin
        if (!reset) begin
            r_din   <= 8'h00;
            r_wr_en <= 1'b0;
            r_err   <= 1'b0;
            r_timer <= '0;
        end else begin
            r_wr_en <= w_pop;
            if (w_pop) begin
                r_din   <= r_mem[r_rd_ptr];
                r_timer <= '0;
            end else if (w_timer_inc) begin
                r_timer <= r_timer + C_TMR_ONE;
            end
            if (w_set_err) begin
                r_err <= 1'b1;
            end
        end
    end

    assign s_ready     = !w_full;
    assign uart_din    = r_din;
    assign uart_wr_en  = r_wr_en;
    assign fifo_count  = r_count;
    assign fifo_empty  = w_empty;
    assign idle        = w_empty && (r_state == ST_IDLE) && !uart_tx_busy;
    assign timeout_err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_feeder
//  Purpose  : Self-checking bench for uart_tx_feeder. A queue-based model of
//             the buffered writer predicts every output each cycle; a small
//             transmitter model answers write strobes with tx_busy.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_feeder;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int BT     = 64;

    localparam int XM_NORMAL = 0;
    localparam int XM_HOLD   = 1;
    localparam int XM_IGNORE = 2;

    logic              clk;
    logic              rst_n;
    logic [7:0]        s_data;
    logic              s_valid;
    logic              s_ready;
    logic [7:0]        uart_din;
    logic              uart_wr_en;
    logic              uart_tx_busy = 1'b0;
    logic [ADDR_W:0]   fifo_count;
    logic              fifo_empty;
    logic              idle;
    logic              timeout_err;

    uart_tx_feeder #(
        .DEPTH        (DEPTH),
        .ADDR_W       (ADDR_W),
        .BUSY_TIMEOUT (BT)
    ) dut (
        .system_clk   (clk),
        .reset        (rst_n),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .uart_din     (uart_din),
        .uart_wr_en   (uart_wr_en),
        .uart_tx_busy (uart_tx_busy),
        .fifo_count   (fifo_count),
        .fifo_empty   (fifo_empty),
        .idle         (idle),
        .timeout_err  (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_strobes = 0;
    int          cyc = 0;
    logic        chk_en = 1'b0;
    logic        prev_wr = 1'b0;
    logic [7:0]  out_q[$];

    int          xmode = XM_NORMAL;
    int          frame_len = 100;
    int          xcnt = 0;
    logic        wr_d = 1'b0;

    // Behavioural model state: queued bytes plus the bookkeeping of the
    // byte currently handed to the transmitter.
    logic [7:0]  m_q[$];
    logic        m_wr = 1'b0;
    logic [7:0]  m_din = 8'h00;
    logic        m_err = 1'b0;
    logic        m_armed = 1'b0;
    logic        m_inframe = 1'b0;
    int          m_age = 0;
    logic        m_do_pop;
    logic        m_do_push;
    logic        exp_idle;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expire(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired before the awaited event (t=%0t)", name, $time);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter: busy rises one clock after it sees wr_en and lasts
    // frame_len clocks; HOLD keeps it high, IGNORE never raises it.
    always @(posedge clk) begin
        #2;
        case (xmode)
            XM_NORMAL: begin
                if (uart_tx_busy) begin
                    if (xcnt <= 1) uart_tx_busy = 1'b0;
                    else xcnt--;
                end else if (wr_d) begin
                    uart_tx_busy = 1'b1;
                    xcnt = frame_len;
                end
            end
            XM_HOLD: begin
                if (wr_d) uart_tx_busy = 1'b1;
            end
            default: uart_tx_busy = 1'b0;
        endcase
        wr_d = uart_wr_en;
    end

    // Reference model: one step per rising edge from the inputs seen there.
    always @(posedge clk or negedge rst_n) begin : p_model
        if (!rst_n) begin
            m_q.delete();
            m_wr      = 1'b0;
            m_din     = 8'h00;
            m_err     = 1'b0;
            m_armed   = 1'b0;
            m_inframe = 1'b0;
            m_age     = 0;
        end else begin
            m_do_pop  = !m_armed && !m_inframe && (m_q.size() != 0) && !uart_tx_busy;
            m_do_push = s_valid && (m_q.size() < DEPTH);
            m_wr = 1'b0;
            if (m_armed) begin
                if (uart_tx_busy) begin
                    m_armed   = 1'b0;
                    m_inframe = 1'b1;
                end else begin
                    m_age++;
                    if (m_age == BT) begin
                        m_err   = 1'b1;
                        m_armed = 1'b0;
                    end
                end
            end else if (m_inframe && !uart_tx_busy) begin
                m_inframe = 1'b0;
            end
            if (m_do_pop) begin
                m_din   = m_q[0];
                m_wr    = 1'b1;
                m_armed = 1'b1;
                m_age   = 0;
            end
            if (m_do_push) m_q.push_back(s_data);
            if (m_do_pop) void'(m_q.pop_front());
        end
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            exp_idle = (m_q.size() == 0) && !m_armed && !m_inframe && !uart_tx_busy;
            chk("s_ready",     32'(s_ready),     32'(m_q.size() != DEPTH));
            chk("fifo_count",  32'(fifo_count),  32'(m_q.size()));
            chk("fifo_bound",  32'(fifo_count <= DEPTH), 32'(1));
            chk("fifo_empty",  32'(fifo_empty),  32'(m_q.size() == 0));
            chk("uart_wr_en",  32'(uart_wr_en),  32'(m_wr));
            chk("uart_din",    32'(uart_din),    32'(m_din));
            chk("idle",        32'(idle),        32'(exp_idle));
            chk("timeout_err", 32'(timeout_err), 32'(m_err));
            if (uart_wr_en) begin
                out_q.push_back(uart_din);
                n_strobes++;
                chk("strobe_while_busy",   32'(uart_tx_busy), 32'(0));
                chk("strobe_back_to_back", 32'(prev_wr),      32'(0));
            end
            prev_wr = uart_wr_en;
        end
    end

    task automatic push(input logic [7:0] b);
        int n;
        logic done;
        n = 0;
        done = 1'b0;
        s_data  = b;
        s_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (s_ready) begin
                done = 1'b1;
            end else begin
                n++;
                if (n > 300) begin
                    expire("push_stall");
                    done = 1'b1;
                end
            end
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        @(negedge clk);
        while (!(idle && fifo_empty)) begin
            n++;
            if (n > bound) begin
                expire("wait_idle");
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_strobe(input int bound);
        int n;
        n = 0;
        @(negedge clk);
        while (!uart_wr_en && n < bound) begin
            n++;
            @(negedge clk);
        end
        if (!uart_wr_en) expire("wait_strobe");
    endtask

    int          base;
    int          s0;
    int          t0;
    int          n;
    logic [7:0]  bx [5];
    logic [7:0]  xb;
    logic [7:0]  rb [40];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b1;
        s_valid = 1'b0;
        s_data  = 8'h00;
        #1 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset values
        @(negedge clk);
        chk("rst_s_ready",    32'(s_ready),     32'(1));
        chk("rst_uart_din",   32'(uart_din),    32'(0));
        chk("rst_wr_en",      32'(uart_wr_en),  32'(0));
        chk("rst_count",      32'(fifo_count),  32'(0));
        chk("rst_empty",      32'(fifo_empty),  32'(1));
        chk("rst_idle",       32'(idle),        32'(1));
        chk("rst_timeout",    32'(timeout_err), 32'(0));

        // Single byte: strobe two clocks after the push
        @(posedge clk); #1;
        xmode = XM_NORMAL;
        frame_len = 100;
        s0 = n_strobes;
        s_data = 8'hA5; s_valid = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b0;
        @(negedge clk);
        chk("single_count_after_push", 32'(fifo_count), 32'(1));
        chk("single_no_early_strobe",  32'(uart_wr_en), 32'(0));
        chk("model_single_depth",      32'(m_q.size()), 32'(1));
        @(negedge clk);
        chk("single_strobe",           32'(uart_wr_en), 32'(1));
        chk("single_din",              32'(uart_din),   32'(8'hA5));
        chk("single_count_after_pop",  32'(fifo_count), 32'(0));
        chk("model_single_wr",         32'(m_wr),       32'(1));
        chk("model_single_din",        32'(m_din),      32'(8'hA5));
        wait_idle(300);
        chk("single_one_pulse", 32'(n_strobes - s0), 32'(1));
        chk("single_idle_again", 32'(idle), 32'(1));

        // Fill to full with the transmitter held busy after the first byte
        xmode = XM_HOLD;
        base = out_q.size();
        for (int i = 0; i <= 16; i++) push(8'(i));
        @(negedge clk);
        chk("full_count", 32'(fifo_count), 32'(16));
        chk("full_ready", 32'(s_ready),    32'(0));
        chk("model_full_depth", 32'(m_q.size()), 32'(16));
        s_data = 8'h11; s_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("full_stall_ready", 32'(s_ready),    32'(0));
            chk("full_stall_count", 32'(fifo_count), 32'(16));
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
        chk("full_in_flight", 32'(out_q.size() - base), 32'(1));
        xmode = XM_NORMAL;
        frame_len = 3;
        wait_idle(800);
        chk("full_out_len", 32'(out_q.size() - base), 32'(17));
        for (int i = 0; i <= 16; i++) chk("full_out_order", 32'(out_q[base + i]), 32'(i));

        // Simultaneous push and pop with five bytes queued
        xmode = XM_HOLD;
        base = out_q.size();
        push(8'h11);
        n = 0;
        while (!uart_tx_busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!uart_tx_busy) expire("sim_busy_rise");
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            bx[i] = 8'($urandom);
            push(bx[i]);
        end
        @(negedge clk);
        chk("sim_count_before", 32'(fifo_count), 32'(5));
        @(posedge clk); #1;
        xmode = XM_NORMAL;
        @(posedge clk); #1;
        xb = 8'($urandom);
        s_data = xb; s_valid = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b0;
        @(negedge clk);
        chk("sim_strobe", 32'(uart_wr_en), 32'(1));
        chk("sim_count",  32'(fifo_count), 32'(5));
        chk("sim_din",    32'(uart_din),   32'(bx[0]));
        wait_idle(400);
        chk("sim_out_len", 32'(out_q.size() - base), 32'(7));
        chk("sim_out_0", 32'(out_q[base]), 32'(8'h11));
        for (int i = 0; i < 5; i++) chk("sim_out_q", 32'(out_q[base + 1 + i]), 32'(bx[i]));
        chk("sim_out_new", 32'(out_q[base + 6]), 32'(xb));

        // Pointer wrap: random bytes with random gaps and frame lengths
        base = out_q.size();
        for (int i = 0; i < 40; i++) begin
            frame_len = $urandom_range(1, 6);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
            rb[i] = 8'($urandom);
            push(rb[i]);
        end
        wait_idle(1500);
        chk("wrap_out_len", 32'(out_q.size() - base), 32'(40));
        for (int i = 0; i < 40; i++) chk("wrap_out_order", 32'(out_q[base + i]), 32'(rb[i]));

        // Timeout: transmitter ignores the strobe
        xmode = XM_IGNORE;
        push(8'h3C);
        wait_strobe(20);
        t0 = cyc;
        chk("tmo_first_din", 32'(uart_din), 32'(8'h3C));
        @(posedge clk); #1;
        push(8'h7E);
        n = 0;
        while (!timeout_err && n < BT + 20) begin
            @(negedge clk);
            n++;
        end
        if (!timeout_err) expire("tmo_rise");
        chk("tmo_latency", 32'(cyc - t0), 32'(BT));
        wait_strobe(10);
        chk("tmo_second_din", 32'(uart_din), 32'(8'h7E));
        @(posedge clk); #1;
        wait_idle(BT + 40);
        chk("tmo_sticky", 32'(timeout_err), 32'(1));

        // Reset in the middle of a frame with six bytes queued
        xmode = XM_HOLD;
        push(8'h55);
        n = 0;
        while (!uart_tx_busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!uart_tx_busy) expire("rst_busy_rise");
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) push(8'($urandom));
        @(negedge clk);
        chk("mid_count_queued", 32'(fifo_count), 32'(6));
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wr_en",   32'(uart_wr_en),  32'(0));
        chk("mid_rst_count",   32'(fifo_count),  32'(0));
        chk("mid_rst_ready",   32'(s_ready),     32'(1));
        chk("mid_rst_timeout", 32'(timeout_err), 32'(0));
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        s0 = n_strobes;
        repeat (10) @(negedge clk);
        chk("mid_no_strobe_busy", 32'(n_strobes - s0), 32'(0));
        chk("mid_idle_blocked",   32'(idle),           32'(0));
        @(posedge clk); #1;
        xmode = XM_NORMAL;
        frame_len = 3;
        repeat (5) @(negedge clk);
        chk("mid_no_strobe_empty", 32'(n_strobes - s0), 32'(0));
        chk("mid_idle_free",       32'(idle),           32'(1));
        @(posedge clk); #1;
        push(8'h99);
        wait_idle(100);
        chk("mid_new_strobe", 32'(n_strobes - s0), 32'(1));
        chk("mid_new_din",    32'(out_q[out_q.size() - 1]), 32'(8'h99));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
